vga_rx_monitor: RTL and testbench

Receive-side monitor for the 640x480 VGA stream produced by the game top level. It samples `hsync`, `vsync` and 4:4:4 RGB at the pixel rate, recovers pixel coordinates, checks sync timing against the 800x525 frame format, and reports lock and errors. It also emits the visible pixel stream and an optional per-frame signature. It sits in the simulation bench and in on-chip self-test, wired to the same `hsync`/`vsync`/`vgaRed`/`vgaGreen`/`vgaBlue` nets that drive the connector.

---
 rtl/vga_rx_pkg.sv | 34 +++
 rtl/vga_rx_crc16.sv | 21 ++
 rtl/vga_rx_monitor.sv | 241 ++++++++++++++++++++++++
 tb/tb_vga_rx_monitor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_rx_pkg.sv
// Shared timing defaults, error-bit indices, FSM states and CRC constants
// for the VGA receive monitor.
package vga_rx_pkg;

  localparam int H_VIS_DEF        = 640;
  localparam int H_TOTAL_DEF      = 800;
  localparam int H_SYNC_START_DEF = 656;
  localparam int H_SYNC_W_DEF     = 96;
  localparam int V_VIS_DEF        = 480;
  localparam int V_TOTAL_DEF      = 525;
  localparam int V_SYNC_START_DEF = 490;
  localparam int V_SYNC_W_DEF     = 2;
  localparam int LOCK_FRAMES_DEF  = 2;

  localparam int ERR_H     = 0;
  localparam int ERR_V     = 1;
  localparam int ERR_BLANK = 2;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  // Saturating increment so a stuck sync cannot wrap a width counter back
  // into a value that looks legal.
  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_rx_crc16.sv
// One-step CRC-16-CCITT update consuming a 12-bit pixel, MSB first.
module vga_rx_crc16
  import vga_rx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [11:0] data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 11; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: coordinate recovery, sync timing checks, lock FSM and
// visible pixel stream. Define VGA_RX_CRC_EN to build the per-frame CRC signature.
module vga_rx_monitor
  import vga_rx_pkg::*;
#(
  parameter int H_VIS        = H_VIS_DEF,
  parameter int H_TOTAL      = H_TOTAL_DEF,
  parameter int H_SYNC_START = H_SYNC_START_DEF,
  parameter int H_SYNC_W     = H_SYNC_W_DEF,
  parameter int V_VIS        = V_VIS_DEF,
  parameter int V_TOTAL      = V_TOTAL_DEF,
  parameter int V_SYNC_START = V_SYNC_START_DEF,
  parameter int V_SYNC_W     = V_SYNC_W_DEF,
  parameter int LOCK_FRAMES  = LOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pixpulse,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  vgaRed,
  input  logic [3:0]  vgaGreen,
  input  logic [3:0]  vgaBlue,
  input  logic        err_clr,
  output logic        locked,
  output logic [9:0]  hcount_rx,
  output logic [9:0]  vcount_rx,
  output logic        pix_valid,
  output logic [11:0] pix_data,
  output logic        frame_done,
  output logic [15:0] frame_sig,
  output logic [2:0]  err
);

  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SS    = 10'(H_SYNC_START);
  localparam logic [9:0] H_SW    = 10'(H_SYNC_W);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_TOT_L = 10'(V_TOTAL);
  localparam logic [9:0] V_SS    = 10'(V_SYNC_START);
  localparam logic [9:0] V_SW    = 10'(V_SYNC_W);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

  logic [11:0] rgb_in;
  logic        hfall, hrise, vfall, vrise;

  rx_state_e   state_q, state_d;
  logic        hs_q, hs_d, vs_q, vs_d;
  logic [11:0] pix_data_q, pix_data_d;
  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic [9:0]  h_per_q, h_per_d, hs_low_q, hs_low_d;
  logic [9:0]  v_lines_q, v_lines_d, vs_low_q, vs_low_d;
  logic [7:0]  clean_q, clean_d, clean_inc;
  logic        dirty_q, dirty_d;
  logic        locked_q, locked_d, pix_valid_q, pix_valid_d;
  logic        frame_done_q, frame_done_d;
  logic [2:0]  err_q, err_d, new_err;
  logic        h_err, v_err, b_err, checking;

  assign rgb_in = {vgaRed, vgaGreen, vgaBlue};
  assign hfall  = pixpulse &  hs_q & ~hsync;
  assign hrise  = pixpulse & ~hs_q &  hsync;
  assign vfall  = pixpulse &  vs_q & ~vsync;
  assign vrise  = pixpulse & ~vs_q &  vsync;
  assign clean_inc = clean_q + 8'd1;

  always_comb begin
    hs_d         = hs_q;
    vs_d         = vs_q;
    pix_data_d   = pix_data_q;
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    h_per_d      = h_per_q;
    hs_low_d     = hs_low_q;
    v_lines_d    = v_lines_q;
    vs_low_d     = vs_low_q;
    h_err        = 1'b0;
    v_err        = 1'b0;
    b_err        = 1'b0;

    if (pixpulse) begin
      hs_d       = hsync;
      vs_d       = vsync;
      pix_data_d = rgb_in;

      if (hfall)                  hcount_d = H_SS;
      else if (hcount_q == H_LAST) hcount_d = 10'd0;
      else                        hcount_d = hcount_q + 10'd1;

      if (vfall)                  vcount_d = V_SS;
      else if (hcount_d == 10'd0) vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;

      // h_per counts pixels since the last hsync fall, wrapping like the line counter
      h_per_d = hfall ? 10'd0 : ((h_per_q == H_LAST) ? 10'd0 : h_per_q + 10'd1);
      if (hfall && h_per_q != H_LAST) h_err = 1'b1;

      hs_low_d = hfall ? 10'd1 : (~hsync ? sat_inc(hs_low_q) : hs_low_q);
      if (hrise && hs_low_q != H_SW) h_err = 1'b1;

      // Lines are counted as hsync falls, both per frame and while vsync is low
      v_lines_d = vfall ? 10'd0 : v_lines_q;
      if (hfall) v_lines_d = sat_inc(v_lines_d);
      if (vfall && v_lines_q != V_TOT_L) v_err = 1'b1;

      vs_low_d = vfall ? 10'd0 : vs_low_q;
      if (hfall && ~vsync) vs_low_d = sat_inc(vs_low_d);
      if (vrise && vs_low_q != V_SW) v_err = 1'b1;

      if (rgb_in != 12'h000 && (hcount_d >= H_VIS_L || vcount_d >= V_VIS_L)) b_err = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    clean_d  = clean_q;
    dirty_d  = dirty_q;
    checking = (state_q != HUNT);

    case (state_q)
      HUNT: begin
        if (vfall) begin
          state_d = TRACK;
          clean_d = 8'd0;
          dirty_d = 1'b0;
        end
      end
      TRACK: begin
        dirty_d = dirty_q | h_err | v_err;
        if (vfall) begin
          dirty_d = 1'b0;
          if (dirty_q || h_err || v_err) begin
            clean_d = 8'd0;
          end else if (clean_inc >= LOCK_N) begin
            state_d = LOCKED;
            clean_d = 8'd0;
          end else begin
            clean_d = clean_inc;
          end
        end
      end
      LOCKED: begin
        if (h_err || v_err) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase

    new_err            = 3'b000;
    new_err[ERR_H]     = h_err & checking;
    new_err[ERR_V]     = v_err & checking;
    new_err[ERR_BLANK] = b_err & checking;
    err_d = (err_clr ? 3'b000 : err_q) | new_err;

    locked_d     = (state_d == LOCKED);
    pix_valid_d  = pixpulse && (state_d == LOCKED) &&
                   (hcount_d < H_VIS_L) && (vcount_d < V_VIS_L);
    frame_done_d = pix_valid_d && (hcount_d == H_VIS_L - 10'd1) &&
                   (vcount_d == V_VIS_L - 10'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= HUNT;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      pix_data_q   <= 12'h000;
      hcount_q     <= 10'd0;
      vcount_q     <= 10'd0;
      h_per_q      <= 10'd0;
      hs_low_q     <= 10'd0;
      v_lines_q    <= 10'd0;
      vs_low_q     <= 10'd0;
      clean_q      <= 8'd0;
      dirty_q      <= 1'b0;
      locked_q     <= 1'b0;
      pix_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 3'b000;
    end else begin
      state_q      <= state_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      pix_data_q   <= pix_data_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      h_per_q      <= h_per_d;
      hs_low_q     <= hs_low_d;
      v_lines_q    <= v_lines_d;
      vs_low_q     <= vs_low_d;
      clean_q      <= clean_d;
      dirty_q      <= dirty_d;
      locked_q     <= locked_d;
      pix_valid_q  <= pix_valid_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] sig_acc_q, sig_acc_d, frame_sig_q, frame_sig_d;
  logic [15:0] crc_base, crc_next;

  // Pixel (0,0) restarts the running CRC from the seed
  assign crc_base = (hcount_d == 10'd0 && vcount_d == 10'd0) ? CRC_INIT : sig_acc_q;

  vga_rx_crc16 u_crc (
    .crc_in  (crc_base),
    .data    (rgb_in),
    .crc_out (crc_next)
  );

  always_comb begin
    sig_acc_d   = pix_valid_d  ? crc_next  : sig_acc_q;
    frame_sig_d = frame_done_q ? sig_acc_q : frame_sig_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_acc_q   <= 16'h0000;
      frame_sig_q <= 16'h0000;
    end else begin
      sig_acc_q   <= sig_acc_d;
      frame_sig_q <= frame_sig_d;
    end
  end

  assign frame_sig = frame_sig_q;
`else
  assign frame_sig = 16'h0000;
`endif

  assign locked     = locked_q;
  assign hcount_rx  = hcount_q;
  assign vcount_rx  = vcount_q;
  assign pix_valid  = pix_valid_q;
  assign pix_data   = pix_data_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a scaled-down 16x8 frame (8x4 visible).
module tb_vga_rx_monitor;

  localparam int HV = 8, HT = 16, HSS = 10, HSW = 3;
  localparam int VV = 4, VT = 8, VSS = 5, VSW = 2, LF = 2;
  localparam int FR = HT * VT;
  localparam int LN = HT;

  logic clk = 1'b0;
  logic rst = 1'b1, pixpulse = 1'b0, hsync = 1'b1, vsync = 1'b1, err_clr = 1'b0;
  logic [3:0] r = 4'h0, g = 4'h0, b = 4'h0;
  logic        locked, pix_valid, frame_done;
  logic [9:0]  hcount_rx, vcount_rx;
  logic [11:0] pix_data;
  logic [15:0] frame_sig;
  logic [2:0]  err;

  always #5 clk = ~clk;

  vga_rx_monitor #(
    .H_VIS(HV), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_W(HSW),
    .V_VIS(VV), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_W(VSW),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hsync(hsync), .vsync(vsync),
    .vgaRed(r), .vgaGreen(g), .vgaBlue(b), .err_clr(err_clr),
    .locked(locked), .hcount_rx(hcount_rx), .vcount_rx(vcount_rx),
    .pix_valid(pix_valid), .pix_data(pix_data), .frame_done(frame_done),
    .frame_sig(frame_sig), .err(err)
  );

`ifdef VGA_RX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  int n_total = 0, n_pass = 0;
  int gh = 0, gv = 0;
  int short_line = -1, poke_h = -1, poke_v = -1;
  logic [11:0] poke_rgb = 12'h000;
  logic [11:0] vis_rgb = 12'h0f0;
  int pv_cnt = 0, bad_cnt = 0, fd_cnt = 0;
  logic [15:0] sig_a, sig_exp;

  always @(negedge clk) begin
    if (pix_valid) begin
      pv_cnt++;
      if (pix_data !== vis_rgb) bad_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One pixel: drive at a negedge, pixpulse for one clk, then idle; an extra
  // gap at column 5 shows that idle clocks do not advance the counters.
  task automatic send_px();
    logic [11:0] c;
    int hw;
    hw = (gv == short_line) ? HSW - 1 : HSW;
    c = (gh < HV && gv < VV) ? vis_rgb : 12'h000;
    if (gh == poke_h && gv == poke_v) c = poke_rgb;
    hsync = !(gh >= HSS && gh < HSS + hw);
    vsync = !(gv >= VSS && gv < VSS + VSW);
    {r, g, b} = c;
    pixpulse = 1'b1;
    @(negedge clk);
    pixpulse = 1'b0;
    repeat ((gh == 5) ? 7 : 3) @(negedge clk);
    gh++;
    if (gh == HT) begin
      gh = 0;
      gv++;
      if (gv == VT) gv = 0;
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) send_px();
  endtask

  function automatic logic [15:0] crc_ref(input logic [11:0] first);
    logic [15:0] c;
    logic [11:0] d;
    c = 16'hFFFF;
    for (int v = 0; v < VV; v++) begin
      for (int h = 0; h < HV; h++) begin
        d = (h == 0 && v == 0) ? first : 12'h0f0;
        c = c ^ {d, 4'h0};
        for (int k = 0; k < 12; k++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
    end
    return c;
  endfunction

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_locked"},     32'(locked),     32'd0);
    check({pfx, "_pix_valid"},  32'(pix_valid),  32'd0);
    check({pfx, "_pix_data"},   32'(pix_data),   32'd0);
    check({pfx, "_hcount"},     32'(hcount_rx),  32'd0);
    check({pfx, "_vcount"},     32'(vcount_rx),  32'd0);
    check({pfx, "_frame_done"}, 32'(frame_done), 32'd0);
    check({pfx, "_frame_sig"},  32'(frame_sig),  32'd0);
    check({pfx, "_err"},        32'(err),        32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    @(negedge clk);

    // Lock: HUNT until vsync fall 1, clean frames end at falls 2 and 3
    step(2 * FR + VSS * LN);
    check("pre_lock", 32'(locked), 32'd0);
    step(1);
    check("lock_3rd_vfall", 32'(locked), 32'd1);
    step(FR - VSS * LN - 1);

    // Frame 3: full locked frame
    pv_cnt = 0; bad_cnt = 0; fd_cnt = 0;
    step(2 * LN + 4);
    check("hcount_3_2", 32'(hcount_rx), 32'd3);
    check("vcount_3_2", 32'(vcount_rx), 32'd2);
    check("pix_data_3_2", 32'(pix_data), 32'h0f0);
    step(FR - (2 * LN + 4));
    check("pv_count", 32'(pv_cnt), 32'(HV * VV));
    check("pv_data_bad", 32'(bad_cnt), 32'd0);
    check("frame_done_cnt", 32'(fd_cnt), 32'd1);
    check("err_nominal", 32'(err), 32'd0);
    check("locked_nominal", 32'(locked), 32'd1);
    sig_exp = CRC_ON ? crc_ref(12'h0f0) : 16'h0000;
    check("sig_frame3", 32'(frame_sig), 32'(sig_exp));
    sig_a = frame_sig;

    // Frame 4: identical content
    step(FR);
    check("sig_frame4", 32'(frame_sig), 32'(sig_exp));
`ifdef VGA_RX_CRC_EN
    check("sig_repeat", 32'(frame_sig), 32'(sig_a));
    check("sig_nonzero", 32'(frame_sig != 16'h0000), 32'd1);
`endif

    // Frame 5: pixel (0,0) altered
    poke_h = 0; poke_v = 0; poke_rgb = 12'h0f1;
    step(FR);
    poke_h = -1; poke_v = -1;
    sig_exp = CRC_ON ? crc_ref(12'h0f1) : 16'h0000;
    check("sig_poked", 32'(frame_sig), 32'(sig_exp));
`ifdef VGA_RX_CRC_EN
    check("sig_changed", 32'(frame_sig != sig_a), 32'd1);
`endif

    // Frame 6: colour in horizontal blanking at (12,1)
    poke_h = 12; poke_v = 1; poke_rgb = 12'h001;
    step(LN + 13);
    poke_h = -1; poke_v = -1;
    check("blank_err", 32'(err), 32'b100);
    check("blank_keeps_lock", 32'(locked), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_clr", 32'(err), 32'd0);
    step(FR - (LN + 13));

    // Frame 7: hsync on line 2 one pixel short
    short_line = 2;
    step(2 * LN + HSS + HSW - 1);
    check("locked_before_rise", 32'(locked), 32'd1);
    step(1);
    short_line = -1;
    check("short_h_err", 32'(err), 32'b001);
    check("short_h_unlock", 32'(locked), 32'd0);
    step(FR - (2 * LN + HSS + HSW));

    // Relock: vsync fall in frame 7 re-enters TRACK, frames 8 and 9 clean
    step(FR);
    step(VSS * LN);
    check("pre_relock", 32'(locked), 32'd0);
    step(1);
    check("relock", 32'(locked), 32'd1);
    step(FR - VSS * LN - 1);

    // Frame 10: reset for one clk at (4,2)
    fd_cnt = 0;
    step(2 * LN + 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("midrst");
    step(FR - (2 * LN + 5));
    check("midrst_no_frame_done", 32'(fd_cnt), 32'd0);
    check("midrst_unlocked", 32'(locked), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
